// File: rtl/tw_rom_sequencer.sv
// ---------------------------------------------------------------------------
// tw_rom_sequencer
//   Control FSM for the radix-16 twiddle ROM. For one NTT pass it steps the
//   ROM through STAGE_NUM stages of CYC_PER_STAGE read cycles each, separated
//   by GAP_CYCLES flush cycles. Optionally it first collects INIT_STORE_DATA
//   new row-0 twiddles and writes them into the ROM as one unbroken burst.
//
// Ports
//   CLK, rst_n          clock (rising edge), asynchronous active-low reset
//   start, load_en      pass request (IDLE only); load_en selects a row-0 reload
//   in_valid/in_ready   row-0 word handshake, in_data is the word
//   stall               butterfly back-pressure, freezes issue in RUN only
//   stage_counter, CEN, state, ROM0_w, horizontal_row0_in   ROM control pins
//   busy, done          pass status towards the NTT controller
// ---------------------------------------------------------------------------
module tw_rom_sequencer #(
  parameter int SC_WIDTH        = 3,
  parameter int S_WIDTH         = 4,
  parameter int P_WIDTH         = 64,
  parameter int STAGE_NUM       = 3,
  parameter int INIT_STORE_DATA = 4,
  parameter int CYC_PER_STAGE   = 64,
  parameter int GAP_CYCLES      = 2,
  parameter int CNT_WIDTH       = 10
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                start,
  input  logic                load_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [P_WIDTH-1:0]  in_data,
  input  logic                stall,
  output logic [SC_WIDTH-1:0] stage_counter,
  output logic                CEN,
  output logic [S_WIDTH-1:0]  state,
  output logic                ROM0_w,
  output logic [P_WIDTH-1:0]  horizontal_row0_in,
  output logic                busy,
  output logic                done
);

  localparam int IDX_W = (INIT_STORE_DATA > 1) ? $clog2(INIT_STORE_DATA) : 1;

  // Encodings are the codes the ROM expects on its state pins.
  typedef enum logic [S_WIDTH-1:0] {
    ST_IDLE    = S_WIDTH'(0),
    ST_COLLECT = S_WIDTH'(1),
    ST_BURST   = S_WIDTH'(2),
    ST_RUN     = S_WIDTH'(4),
    ST_GAP     = S_WIDTH'(5),
    ST_DONE    = S_WIDTH'(7)
  } fsm_t;

  fsm_t                r_state;
  fsm_t                w_state_next;
  logic [SC_WIDTH-1:0]  r_stage;
  logic [CNT_WIDTH-1:0] r_issue_cnt;
  logic [CNT_WIDTH-1:0] r_gap_cnt;
  logic [IDX_W-1:0]     r_idx;       // write index in COLLECT, word index in BURST
  logic [P_WIDTH-1:0]   r_buf [INIT_STORE_DATA];
  logic                 r_in_ready;
  logic                 r_rom0_w;
  logic [P_WIDTH-1:0]   r_row0;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_issue;
  logic                 w_hs;
  logic                 w_last_idx;
  logic                 w_stage_end;
  logic                 w_last_stage;
  logic                 w_gap_end;
  logic [IDX_W-1:0]     w_rd_idx;

  assign w_issue      = (r_state == ST_RUN) && !stall;
  assign w_hs         = (r_state == ST_COLLECT) && in_valid && r_in_ready;
  assign w_last_idx   = (r_idx == IDX_W'(INIT_STORE_DATA - 1));
  assign w_stage_end  = w_issue && (r_issue_cnt == CNT_WIDTH'(CYC_PER_STAGE - 1));
  assign w_last_stage = (r_stage == SC_WIDTH'(STAGE_NUM - 1));
  assign w_gap_end    = (r_gap_cnt == CNT_WIDTH'(GAP_CYCLES - 1));
  // Word to present next: word 0 when entering BURST, else the following word.
  assign w_rd_idx     = (r_state == ST_BURST) ? r_idx + IDX_W'(1) : '0;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_next = load_en ? ST_COLLECT : ST_RUN;
      ST_COLLECT: if (w_hs && w_last_idx) w_state_next = ST_BURST;
      // Fixed length, never paused: the ROM restarts its write index when ROM0_w drops.
      ST_BURST:   if (w_last_idx) w_state_next = ST_RUN;
      ST_RUN:     if (w_stage_end) w_state_next = w_last_stage ? ST_DONE : ST_GAP;
      ST_GAP:     if (w_gap_end) w_state_next = ST_RUN;
      ST_DONE:    w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- row-0 buffer ----------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INIT_STORE_DATA; i++) r_buf[i] <= '0;
    end else if (w_hs) begin
      r_buf[r_idx] <= in_data;
    end
  end

  // ---------------- counters and registered outputs ----------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_stage     <= '0;
      r_issue_cnt <= '0;
      r_gap_cnt   <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_rom0_w    <= 1'b0;
      r_row0      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Shared index: advances per handshake in COLLECT, per cycle in BURST,
      // and is cleared whenever either phase finishes its last word.
      if ((w_hs || r_state == ST_BURST) && w_last_idx) begin
        r_idx <= '0;
      end else if (w_hs || r_state == ST_BURST) begin
        r_idx <= r_idx + IDX_W'(1);
      end

      if (w_state_next == ST_BURST) begin
        // A single-word buffer is still being written on the entry edge.
        if (INIT_STORE_DATA == 1 && r_state == ST_COLLECT) begin
          r_row0 <= in_data;
        end else begin
          r_row0 <= r_buf[w_rd_idx];
        end
      end else begin
        r_row0 <= '0;
      end
      r_rom0_w <= (w_state_next == ST_BURST);

      if (w_issue) begin
        r_issue_cnt <= w_stage_end ? '0 : r_issue_cnt + CNT_WIDTH'(1);
      end

      if (r_state == ST_GAP && !w_gap_end) begin
        r_gap_cnt <= r_gap_cnt + CNT_WIDTH'(1);
      end else begin
        r_gap_cnt <= '0;
      end

      if (r_state == ST_GAP && w_gap_end) begin
        r_stage <= r_stage + SC_WIDTH'(1);
      end else if (r_state == ST_IDLE || r_state == ST_DONE) begin
        r_stage <= '0;
      end

      r_in_ready <= (w_state_next == ST_COLLECT);
      r_busy     <= (w_state_next != ST_IDLE);
      r_done     <= (w_state_next == ST_DONE);
    end
  end

  assign CEN                = !w_issue;
  assign state              = r_state;
  assign stage_counter      = r_stage;
  assign in_ready           = r_in_ready;
  assign ROM0_w             = r_rom0_w;
  assign horizontal_row0_in = r_row0;
  assign busy               = r_busy;
  assign done               = r_done;

endmodule

// File: tb/tb_tw_rom_sequencer.sv
// Scoreboard bench for tw_rom_sequencer: stimulus pushes expected burst words,
// burst lengths and per-pass timing records; a monitor pops and compares them
// as the DUT produces ROM0_w words and done pulses.
module tb_tw_rom_sequencer;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        start, load_en, in_valid, stall;
  logic        in_ready;
  logic [63:0] in_data;
  logic [2:0]  stage_counter;
  logic        CEN;
  logic [3:0]  state;
  logic        ROM0_w;
  logic [63:0] horizontal_row0_in;
  logic        busy, done;

  always #5 CLK = ~CLK;

  tw_rom_sequencer dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .load_en(load_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .stall(stall),
    .stage_counter(stage_counter), .CEN(CEN), .state(state), .ROM0_w(ROM0_w),
    .horizontal_row0_in(horizontal_row0_in), .busy(busy), .done(done)
  );

  typedef struct {
    int busy_len;   // -1 = not checked
    int run_len;    // first RUN cycle through DONE cycle inclusive
    int low0, low1, low2;
    int gaps;
  } exp_t;

  exp_t        done_q[$];
  logic [63:0] word_q[$];
  int          burst_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    int   busy_len, run_len, gaps, burst_cnt;
    int   lows[3];
    bit   running, prev_rom, prev_done;
    exp_t e;
    busy_len = 0; run_len = 0; gaps = 0; burst_cnt = 0;
    lows = '{0, 0, 0}; running = 0; prev_rom = 0; prev_done = 0;
    forever begin
      @(negedge CLK);
      if (!rst_n) begin
        busy_len = 0; run_len = 0; gaps = 0; burst_cnt = 0;
        lows = '{0, 0, 0}; running = 0; prev_rom = 0; prev_done = 0;
      end else begin
        if (prev_done) begin
          chk("done_width", 64'(done), 64'(0));
          chk("busy_after_done", 64'(busy), 64'(0));
        end
        if (ROM0_w) begin
          if (word_q.size() == 0) chk("rom0w_unexpected", 64'(ROM0_w), 64'(0));
          else chk("rom0_word", horizontal_row0_in, word_q.pop_front());
          burst_cnt++;
        end
        if (prev_rom && !ROM0_w) begin
          if (burst_q.size() == 0) chk("burst_unexpected", 64'(burst_cnt), 64'(0));
          else chk("burst_len", 64'(burst_cnt), 64'(burst_q.pop_front()));
          chk("run_after_burst_state", 64'(state), 64'(4));
          chk("run_after_burst_stage", 64'(stage_counter), 64'(0));
          burst_cnt = 0;
        end
        if (busy) busy_len++;
        if (state == 4'd4) running = 1;
        if (running) run_len++;
        if (!CEN) begin
          if (stage_counter < 3) lows[stage_counter]++;
          else chk("stage_range", 64'(stage_counter), 64'(2));
        end
        if (state == 4'd5) gaps++;
        if (done) begin
          n_done++;
          if (done_q.size() == 0) begin
            chk("done_unexpected", 64'(done), 64'(0));
          end else begin
            e = done_q.pop_front();
            if (e.busy_len >= 0) chk("busy_len", 64'(busy_len), 64'(e.busy_len));
            chk("run_len", 64'(run_len), 64'(e.run_len));
            chk("cen_low_stage0", 64'(lows[0]), 64'(e.low0));
            chk("cen_low_stage1", 64'(lows[1]), 64'(e.low1));
            chk("cen_low_stage2", 64'(lows[2]), 64'(e.low2));
            chk("gap_cycles", 64'(gaps), 64'(e.gaps));
          end
          busy_len = 0; run_len = 0; gaps = 0; lows = '{0, 0, 0}; running = 0;
        end
        prev_rom  = ROM0_w;
        prev_done = done;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_pass(input bit le);
    @(negedge CLK);
    start = 1'b1; load_en = le;
    @(negedge CLK);
    start = 1'b0; load_en = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d, input int gap_after);
    int t;
    in_valid = 1'b1; in_data = d;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 100) chk("in_ready_timeout", 64'(in_ready), 64'(1));
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (gap_after) @(negedge CLK);
  endtask

  task automatic wait_done(input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic push_words(input logic [63:0] a, b, c, d);
    word_q.push_back(a); word_q.push_back(b);
    word_q.push_back(c); word_q.push_back(d);
    burst_q.push_back(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int   seen;
    bit   hit;
    exp_t e_plain, e_load, e_stall;
    e_plain = '{busy_len: 197, run_len: 197, low0: 64, low1: 64, low2: 64, gaps: 4};
    e_load  = '{busy_len: -1,  run_len: 197, low0: 64, low1: 64, low2: 64, gaps: 4};
    e_stall = '{busy_len: 207, run_len: 207, low0: 64, low1: 64, low2: 64, gaps: 4};

    rst_n = 1'b0; start = 1'b0; load_en = 1'b0; in_valid = 1'b0; stall = 1'b0;
    in_data = '0;

    // Reset state.
    repeat (3) @(negedge CLK);
    chk("rst_cen", 64'(CEN), 64'(1));
    chk("rst_rom0w", 64'(ROM0_w), 64'(0));
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_stage", 64'(stage_counter), 64'(0));
    chk("rst_row0", horizontal_row0_in, 64'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge CLK);
    chk("idle_state", 64'(state), 64'(0));
    chk("idle_cen", 64'(CEN), 64'(1));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_rom0w", 64'(ROM0_w), 64'(0));
    $display("txn 1: reset and idle checked");

    // Pass 1: plain pass.
    done_q.push_back(e_plain);
    start_pass(0);
    wait_done(400);
    $display("txn 2: plain pass done");

    // Pass 2: reload row 0 with in_valid gaps 0,3,1.
    push_words(64'hAAAA_0000_0000_000A, 64'hBBBB_1111_0000_000B,
               64'hCCCC_2222_0000_000C, 64'hDDDD_3333_0000_000D);
    done_q.push_back(e_load);
    start_pass(1);
    send_word(64'hAAAA_0000_0000_000A, 0);
    send_word(64'hBBBB_1111_0000_000B, 3);
    send_word(64'hCCCC_2222_0000_000C, 1);
    send_word(64'hDDDD_3333_0000_000D, 0);
    wait_done(400);
    $display("txn 3: load pass done");

    // Pass 3: 10-cycle stall in stage 1.
    done_q.push_back(e_stall);
    start_pass(0);
    hit = 0;
    for (int i = 0; i < 300; i++) begin
      if (state == 4'd4 && stage_counter == 3'd1) begin
        hit = 1;
        break;
      end
      @(negedge CLK);
    end
    if (!hit) chk("stage1_timeout", 64'(stage_counter), 64'(1));
    repeat (20) @(negedge CLK);
    stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("stall_cen", 64'(CEN), 64'(1));
      chk("stall_stage", 64'(stage_counter), 64'(1));
      @(negedge CLK);
    end
    stall = 1'b0;
    wait_done(400);
    $display("txn 4: stalled pass done");

    // Pass 4: start pulsed during RUN and during DONE is ignored.
    done_q.push_back(e_plain);
    start_pass(0);
    repeat (30) @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(400);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    chk("ignored_start_busy", 64'(busy), 64'(0));
    chk("ignored_start_state", 64'(state), 64'(0));
    $display("txn 5: ignored starts checked");

    // Pass 5: reset during BURST after two words.
    push_words(64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
               64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004);
    done_q.push_back(e_load);
    start_pass(1);
    send_word(64'h1111_0000_0000_0001, 0);
    send_word(64'h2222_0000_0000_0002, 0);
    send_word(64'h3333_0000_0000_0003, 0);
    send_word(64'h4444_0000_0000_0004, 0);
    seen = 0;
    for (int t = 0; t < 50; t++) begin
      if (ROM0_w) seen++;
      if (seen == 2) break;
      @(negedge CLK);
    end
    chk("burst_two_words_seen", 64'(seen), 64'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_rom0w", 64'(ROM0_w), 64'(0));
    chk("abort_state", 64'(state), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_cen", 64'(CEN), 64'(1));
    word_q.delete();
    burst_q.delete();
    done_q.delete();
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post_abort_rom0w", 64'(ROM0_w), 64'(0));
    $display("txn 6: reset during burst checked");

    // Pass 6: full reload after the aborted one.
    push_words(64'h5555_AAAA_0000_0005, 64'h6666_BBBB_0000_0006,
               64'h7777_CCCC_0000_0007, 64'h8888_DDDD_0000_0008);
    done_q.push_back(e_load);
    start_pass(1);
    send_word(64'h5555_AAAA_0000_0005, 0);
    send_word(64'h6666_BBBB_0000_0006, 0);
    send_word(64'h7777_CCCC_0000_0007, 0);
    send_word(64'h8888_DDDD_0000_0008, 0);
    wait_done(400);
    repeat (3) @(negedge CLK);
    $display("txn 7: reload after abort done");

    chk("done_count", 64'(n_done), 64'(5));
    chk("done_q_empty", 64'(done_q.size()), 64'(0));
    chk("word_q_empty", 64'(word_q.size()), 64'(0));
    chk("burst_q_empty", 64'(burst_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
